// File: rtl/multi_timer_if.sv
// Register bus for multi_timer: single write strobe, shared address, registered read data.
interface multi_timer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 17
);
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output wr_en,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  wr_en,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel timer: shared prescaler producing a tick, per-channel counters in
// free-run, periodic or one-shot mode, sticky event flags and masked level interrupts.
module multi_timer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned PRE_W     = 17,
  parameter int unsigned PRE_RESET = 90000,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  multi_timer_if.slave        bus,
  output logic                tick,
  output logic [CHANNELS-1:0] irq
);

  localparam int unsigned DW = (WIDTH > PRE_W) ? WIDTH : PRE_W;

  logic [PRE_W-1:0]    pdiv_q, pre_cnt_q;
  logic                pdiv_wr;

  logic [CHANNELS-1:0] en_q, en_d, flag_q, flag_d, ie_q, ie_d;
  logic [1:0]          mode_q  [CHANNELS];
  logic [1:0]          mode_d  [CHANNELS];
  logic [WIDTH-1:0]    load_q  [CHANNELS];
  logic [WIDTH-1:0]    load_d  [CHANNELS];
  logic [WIDTH-1:0]    count_q [CHANNELS];
  logic [WIDTH-1:0]    count_d [CHANNELS];
  logic [CHANNELS-1:0] evt;
  logic [CHANNELS-1:0] irq_q, irq_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  // A PDIV write restarts the prescaler, so it suppresses the tick of that cycle.
  assign pdiv_wr = bus.wr_en && (bus.addr == '0);
  assign tick    = (pre_cnt_q == pdiv_q) && !pdiv_wr;
  assign irq     = irq_q;
  assign bus.rdata = rdata_q;

  // Prescaler: count 0..PDIV, wrap on tick, restart on PDIV write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pdiv_q    <= PRE_W'(PRE_RESET);
      pre_cnt_q <= '0;
    end else if (pdiv_wr) begin
      pdiv_q    <= bus.wdata[PRE_W-1:0];
      pre_cnt_q <= '0;
    end else if (tick) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + PRE_W'(1);
    end
  end

  // Channel next state: count update from pre-write values, then register writes on top.
  always_comb begin
    en_d    = en_q;
    flag_d  = flag_q;
    ie_d    = ie_q;
    mode_d  = mode_q;
    load_d  = load_q;
    count_d = count_q;
    evt     = '0;
    irq_d   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (tick && en_q[c]) begin
        case (mode_q[c])
          2'b01: begin
            if (count_q[c] == '0) begin
              evt[c]     = 1'b1;
              count_d[c] = load_q[c];
            end else begin
              count_d[c] = count_q[c] - WIDTH'(1);
            end
          end
          2'b10: begin
            if (count_q[c] == '0) begin
              evt[c]  = 1'b1;
              en_d[c] = 1'b0;
            end else begin
              count_d[c] = count_q[c] - WIDTH'(1);
            end
          end
          default: begin
            evt[c]     = &count_q[c];
            count_d[c] = count_q[c] + WIDTH'(1);
          end
        endcase
      end
      if (bus.wr_en && (bus.addr == ADDR_W'(4 * (c + 1)))) begin
        en_d[c]   = bus.wdata[0];
        mode_d[c] = bus.wdata[2:1];
        ie_d[c]   = bus.wdata[4];
        if (bus.wdata[3]) flag_d[c] = 1'b0;
      end
      if (bus.wr_en && (bus.addr == ADDR_W'(4 * (c + 1) + 1))) begin
        load_d[c] = bus.wdata[WIDTH-1:0];
      end
      // Software COUNT write overrides the tick update.
      if (bus.wr_en && (bus.addr == ADDR_W'(4 * (c + 1) + 2))) begin
        count_d[c] = bus.wdata[WIDTH-1:0];
      end
      // Event set beats a same-cycle write-1-clear.
      if (evt[c]) flag_d[c] = 1'b1;
      irq_d[c] = flag_d[c] & ie_d[c];
    end
  end

  // Read mux on current (pre-write) register values; reserved addresses read 0.
  always_comb begin
    rdata_d = '0;
    if (bus.addr == '0) rdata_d = DW'(pdiv_q);
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.addr == ADDR_W'(4 * (c + 1))) begin
        rdata_d = DW'({ie_q[c], flag_q[c], mode_q[c], en_q[c]});
      end
      if (bus.addr == ADDR_W'(4 * (c + 1) + 1)) rdata_d = DW'(load_q[c]);
      if (bus.addr == ADDR_W'(4 * (c + 1) + 2)) rdata_d = DW'(count_q[c]);
    end
  end

  // Channel state, interrupt and read data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= '0;
      flag_q  <= '0;
      ie_q    <= '0;
      irq_q   <= '0;
      rdata_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= '0;
        load_q[c]  <= '0;
        count_q[c] <= '0;
      end
    end else begin
      en_q    <= en_d;
      flag_q  <= flag_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= mode_d[c];
        load_q[c]  <= load_d[c];
        count_q[c] <= count_d[c];
      end
    end
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, channel counter/load width.
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent timer channels (1..8).
REQ-003 SHALL have parameter PRE_W, default 17, prescaler counter width.
REQ-004 SHALL have parameter PRE_RESET, default 90000, reset value of prescale divisor PDIV.
REQ-005 SHALL have parameter ADDR_W, default 4, register address width; it SHALL satisfy 2^ADDR_W >= 4*(CHANNELS+1).
REQ-006 SHALL have port clk input 1, the single clock; all state is on its rising edge.
REQ-007 SHALL have port rst input 1, the reset: asynchronous, active-low.
REQ-008 SHALL have port wr_en input 1, register write strobe, one write per cycle.
REQ-009 SHALL have port addr input ADDR_W, register address for read and write.
REQ-010 SHALL have port wdata input max(WIDTH,PRE_W), write data, LSB-aligned.
REQ-011 SHALL have port rdata output max(WIDTH,PRE_W), registered read data for addr.
REQ-012 SHALL have port tick output 1, one-cycle prescaler pulse.
REQ-013 SHALL have port irq output CHANNELS, per-channel level interrupt.

Function
REQ-014 Register map SHALL be: addr 0 = PDIV (PRE_W); channel c base B=4*(c+1): B+0 CTRL, B+1 LOAD (WIDTH), B+2 COUNT (WIDTH); all other addresses reserved.
REQ-015 CTRL SHALL be: bit0 EN, bits2:1 MODE, bit3 FLAG (read 1 = event; write 1 clears, write 0 keeps), bit4 IE; other bits read 0.
REQ-016 Prescaler SHALL count 0..PDIV; tick=1 for exactly the cycle where count==PDIV, next value 0; tick period PDIV+1 clocks; PDIV=0 gives tick every cycle.
REQ-017 A write to PDIV SHALL also zero the prescaler count; no tick in that cycle.
REQ-018 Channels SHALL change COUNT only in cycles with tick=1 and EN=1.
REQ-019 MODE 00 (free-run) and 11 SHALL count up mod 2^WIDTH; wrap from all-ones to 0 sets FLAG.
REQ-020 MODE 01 (periodic) SHALL count down; at COUNT==0 on a tick: set FLAG, load COUNT<=LOAD.
REQ-021 MODE 10 (one-shot) SHALL count down; at COUNT==0 on a tick: set FLAG, clear EN, COUNT stays 0.
REQ-022 LOAD=0 in periodic mode SHALL set FLAG on every tick.
REQ-023 irq[c] SHALL equal FLAG[c] AND IE[c], driven from flops, no combinational path from inputs.
REQ-024 Write to COUNT in a tick cycle SHALL win over the count update; the event check uses the pre-write value.
REQ-025 FLAG set and FLAG write-1-clear in the same cycle: set SHALL win.
REQ-026 Writing CTRL with EN=1 SHALL NOT reload COUNT; software loads COUNT explicitly.
REQ-027 rdata SHALL be valid the cycle after addr is presented (1-cycle latency); reserved addresses read 0.
REQ-028 Writes to reserved addresses SHALL have no effect.
REQ-029 Writes SHALL take effect on the same clock edge; reads in that cycle return the old value.

Reset
REQ-030 rst=0 SHALL asynchronously force: prescaler count 0, PDIV=PRE_RESET, all CTRL/LOAD/COUNT=0, tick=0, irq=0, rdata=0.
REQ-031 Reset mid-count SHALL abandon all pending events; after release, counting resumes only when EN is rewritten.
REQ-032 First tick after reset release SHALL occur PRE_RESET+1 clocks later.

Verification
REQ-033 PDIV=3, ch0 MODE=00 EN=1 COUNT=0xFFFE -> tick every 4 clocks; COUNT 0xFFFF then 0x0000 with FLAG set at wrap; irq[0]=0 with IE=0.
REQ-034 PDIV=0, ch1 LOAD=2 COUNT=2 MODE=01 EN=1 IE=1 -> COUNT 2,1,0,2,... ; irq[1] rises the cycle after COUNT==0 tick; W1C clears it.
REQ-035 PDIV=0, ch0 MODE=10 COUNT=1 EN=1 -> COUNT 1,0; FLAG=1, EN reads 0, COUNT stays 0 for 10 further ticks.
REQ-036 Same-cycle COUNT write 0x55 on a tick -> COUNT=0x55; same-cycle FLAG set and clear -> FLAG=1.
REQ-037 Assert rst=0 mid-operation, off-edge -> all outputs 0 immediately; read addr 0 after release returns 90000.
REQ-038 Read addr 15 (reserved, CHANNELS=2) -> rdata=0; write there -> no register changes.
